// File: rtl/sum_uart_framer_if.sv
// Byte-wide handshake between the frame generator and uart_tx.
interface sum_uart_framer_if;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;

    modport master (output uart_tx_en, output uart_tx_data, input uart_tx_busy);
    modport slave  (input uart_tx_en, input uart_tx_data, output uart_tx_busy);
endinterface

// File: rtl/sum_uart_framer.sv
// Latches two operands from button strobes, adds/subtracts them and sends
// a HEADER / result bytes (LSB first) / XOR checksum frame through uart_tx.
module sum_uart_framer #(
    parameter int unsigned DATA_W = 4,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  save_a_n,
    input  logic                  save_b_n,
    input  logic                  send_n,
    input  logic                  mode,
    input  logic [DATA_W-1:0]     data_input,
    sum_uart_framer_if.master     uart,
    output logic [DATA_W-1:0]     op_a,
    output logic [DATA_W-1:0]     op_b,
    output logic [DATA_W:0]       result,
    output logic                  frame_busy,
    output logic                  overrun
);

    localparam int unsigned RES_W = DATA_W + 1;
    localparam int unsigned NB    = (RES_W + 7) / 8;
    localparam int unsigned SHW   = NB * 8;
    localparam int unsigned IDX_W = $clog2(NB + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t             state, state_d;
    logic [2:0]         a_sync, b_sync, s_sync;
    logic               save_a_ev, save_b_ev, send_ev;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [SHW-1:0]     shift, shift_d;
    logic [7:0]         chk, chk_d;
    logic [7:0]         tx_data, tx_data_d;
    logic               tx_en, tx_en_d;
    logic               fbusy_d, overrun_d;
    logic [DATA_W:0]    sum_c, diff_c;

    // Two-flop synchronisers plus one delay flop for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sync <= 3'b111;
            b_sync <= 3'b111;
            s_sync <= 3'b111;
        end else begin
            a_sync <= {a_sync[1:0], save_a_n};
            b_sync <= {b_sync[1:0], save_b_n};
            s_sync <= {s_sync[1:0], send_n};
        end
    end

    assign save_a_ev = a_sync[2] & ~a_sync[1];
    assign save_b_ev = b_sync[2] & ~b_sync[1];
    assign send_ev   = s_sync[2] & ~s_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a <= '0;
            op_b <= '0;
        end else begin
            if (save_a_ev) op_a <= data_input;
            if (save_b_ev) op_b <= data_input;
        end
    end

    assign sum_c  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_c = {1'b0, op_a} - {1'b0, op_b};
    assign result = mode ? diff_c : sum_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            shift      <= '0;
            chk        <= '0;
            tx_data    <= '0;
            tx_en      <= 1'b0;
            frame_busy <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            shift      <= shift_d;
            chk        <= chk_d;
            tx_data    <= tx_data_d;
            tx_en      <= tx_en_d;
            frame_busy <= fbusy_d;
            overrun    <= overrun_d;
        end
    end

    // Frame sequencing: one byte per LOAD/ISSUE/WAIT_HI/WAIT_LO round trip
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        shift_d   = shift;
        chk_d     = chk;
        tx_data_d = tx_data;
        tx_en_d   = 1'b0;
        fbusy_d   = frame_busy;
        overrun_d = send_ev && (state != IDLE);

        case (state)
            IDLE: begin
                if (send_ev) begin
                    shift_d = SHW'(result);
                    idx_d   = '0;
                    chk_d   = '0;
                    fbusy_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (idx == '0) begin
                    tx_data_d = HEADER;
                end else if (idx == LAST_IDX) begin
                    tx_data_d = chk;
                end else begin
                    tx_data_d = shift[7:0];
                    shift_d   = shift >> 8;
                end
                state_d = ISSUE;
            end
            ISSUE: begin
                if (!uart.uart_tx_busy) begin
                    tx_en_d = 1'b1;
                    chk_d   = chk ^ tx_data;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (uart.uart_tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!uart.uart_tx_busy) begin
                    if (idx == LAST_IDX) begin
                        fbusy_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign uart.uart_tx_en   = tx_en;
    assign uart.uart_tx_data = tx_data;

endmodule

// File: doc/sum_uart_framer.md
Name: sum_uart_framer

Overview:
- Parametrised successor to the two-operand latch/add/UART top.
- Captures two DATA_W-bit operands from a shared input bus using active-low save strobes. Adds or subtracts them, and on an explicit send request emits a framed multi-byte packet through the existing byte-wide uart_tx handshake.
- Sits between board buttons/switches and uart_tx.
- Replaces the free-running uart_tx_en=1 tie with proper one-shot transmit control.

Parameters:
- DATA_W, 4, operand width in bits (1..32); result width is DATA_W+1.
- HEADER, 8'hA5, first byte of every frame.
- NB, derived = ceil((DATA_W+1)/8), number of result bytes in a frame; not user-overridable.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset for all flops.
- save_a_n  in  1  async active-low strobe; falling edge loads data_input into operand A.
- save_b_n  in  1  async active-low strobe; falling edge loads data_input into operand B.
- send_n  in  1  async active-low strobe; falling edge requests one frame.
- mode  in  1  0 = A+B, 1 = A−B; sampled at send event.
- data_input  in  DATA_W  operand bus; treated as stable while a strobe is asserted.
- uart_tx_busy  in  1  from uart_tx; high while a byte is shifting.
- uart_tx_en  out  1  one-cycle pulse requesting transmission of uart_tx_data.
- uart_tx_data  out  8  byte to transmit.
- op_a  out  DATA_W  current operand A.
- op_b  out  DATA_W  current operand B.
- result  out  DATA_W+1  live A±B per current mode (combinational from registers).
- frame_busy  out  1  high from send acceptance until last byte completes.
- overrun  out  1  one-cycle pulse when a send event is dropped.

Behaviour:
Reset values:
- uart_tx_en=0, uart_tx_data=0, op_a=0, op_b=0, frame_busy=0, overrun=0.
- Synchroniser flops reset to 1; FSM=IDLE; checksum=0.

Input conditioning:
- Each strobe passes through a 2-flop synchroniser.
- An event is a synced 1→0 transition, one cycle wide.
- Operand register updates on the 3rd rising clk edge after the strobe fall.
- save_a and save_b events in the same cycle load the same data_input into both operands.
- Operands may change during a frame without affecting it.

Arithmetic:
- Add: zero-extended A + B, carry in bit DATA_W.
- Sub: A − B modulo 2^(DATA_W+1), i.e. two's complement with sign in bit DATA_W.
- Result is zero-padded to NB*8 bits for transmission.

Frame:
- Byte order: HEADER, then result bytes LSB first (NB bytes), then CHK.
- CHK = XOR of HEADER and all result bytes.
- Total length NB+2 bytes.

FSM states: IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO.
- IDLE: on send event, snapshot A±B (mode sampled this cycle) into the shift register, byte index=0, frame_busy=1, go to LOAD.
- LOAD: set uart_tx_data to the current byte; go to ISSUE.
- ISSUE: when uart_tx_busy=0, pulse uart_tx_en for exactly one cycle and fold the byte into the checksum; go to WAIT_HI. While busy=1, hold.
- WAIT_HI: wait for uart_tx_busy=1; go to WAIT_LO.
- WAIT_LO: wait for uart_tx_busy=0. If the last byte (CHK) is done, go to IDLE with frame_busy=0. Otherwise advance the index and go to LOAD.
- uart_tx_data is held stable from LOAD through WAIT_LO.

Latency:
- With uart_tx_busy low, uart_tx_en rises no earlier than 5 clk after the send_n fall.
- Clock count: 2 sync + 1 edge detect + IDLE→LOAD→ISSUE.

Boundary conditions:
- Send event while frame_busy=1: ignored and overrun pulses one cycle; the current frame continues unchanged.
- Send event coincident with a save event: the snapshot uses the operand values before that save.
- Reset asserted mid-frame: outputs return to reset values immediately and asynchronously. The partial frame is abandoned and not resumed after release.
- DATA_W=7 gives NB=1; DATA_W=8 gives NB=2; byte count wraps correctly for every legal DATA_W.
- uart_tx_en never asserts twice for one byte and never asserts while uart_tx_busy=1.

Test Plan:
- DATA_W=4: save A=9, save B=8, mode=0, send → result=5'h11; bytes A5,11,B4; exactly 3 uart_tx_en pulses; frame_busy falls after the 3rd busy low.
- DATA_W=4: A=3, B=5, mode=1, send → result=5'h1E; bytes A5,1E,BB.
- DATA_W=12: A=B=12'hFFF, mode=0 → result=13'h1FFE; bytes A5,FE,1F,44.
- Second send_n fall during an active frame → overrun one-cycle pulse. Frame bytes unchanged and no extra pulses. Change A mid-frame → bytes still carry the snapshot.
- Hold uart_tx_busy=1 at request → uart_tx_en stays 0 until busy falls, then one pulse. Stretch busy to 50 cycles per byte → data held stable throughout.
- Assert reset_n=0 after the 2nd byte → uart_tx_en=0, frame_busy=0, op_a=op_b=0 immediately. After release, a new send produces a full fresh frame starting with A5.
